// File: rtl/mmio_router.sv
// ============================================================================
// Module   : mmio_router
// Purpose  : Memory-mapped I/O request router. It takes one master request at
//            a time and decodes its address against NCH base/mask regions.
//            The request is forwarded to the lowest-index matching slave
//            channel, and the router waits for that slave's srdy pulse. It
//            then returns the read data with a one-cycle ready pulse.
//            Unmapped accesses complete with ERR_DATA and a fault pulse.
// Option   : MMIO_TIMEOUT_EN - when defined, a REQ-state watchdog aborts a
//            slave that has not answered within TIMEOUT cycles. The abort
//            completes as an error.
// Ports    : clk, reset         clock (rising edge), async active-high reset
//            valid/ready        master request / one-cycle completion pulse
//            addr, dtw, rw      master address, write data, direction (1=wr)
//            dtr, fault         read data and error flag, valid with ready
//            sval[NCH]          per-channel slave request (one-hot or zero)
//            srdy[NCH]          per-channel slave completion pulse
//            saddr, sdtw, srw   shared slave address, write data, direction
//            sdtr[NCH*32]       per-channel slave read data, valid with srdy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_router #(
  parameter int unsigned         NCH        = 2,
  parameter logic [NCH*32-1:0]   BASES      = {32'h8000_0000, 32'h0000_0000},
  parameter logic [NCH*32-1:0]   MASKS      = {32'hF000_0000, 32'hF000_0000},
  parameter bit                  STRIP_BASE = 1'b1,
  parameter logic [31:0]         ERR_DATA   = 32'hDEAD_BEEF,
  parameter int unsigned         TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [31:0]       addr,
  input  logic [31:0]       dtw,
  output logic [31:0]       dtr,
  input  logic              rw,
  output logic              fault,
  output logic [NCH-1:0]    sval,
  input  logic [NCH-1:0]    srdy,
  output logic [31:0]       saddr,
  output logic [31:0]       sdtw,
  input  logic [NCH*32-1:0] sdtr,
  output logic              srw
);

  localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1;

  // Elaboration-time sanity check on the configuration.
  if (NCH < 1 || NCH > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("mmio_router: NCH must be 1..8 and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [NCH-1:0]    sval_q, sval_d;
  logic [31:0]       saddr_q, saddr_d;
  logic [31:0]       sdtw_q, sdtw_d;
  logic              srw_q, srw_d;
  logic [31:0]       dtr_q, dtr_d;

`ifdef MMIO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     tmo_q, tmo_d;
`endif

  // Address decode. Scanning from the top index down lets the lowest
  // matching channel overwrite the others, so overlapping regions resolve
  // to a single winner.
  logic              hit;
  logic [SELW-1:0]   hit_idx;
  logic [31:0]       hit_mask;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if ((addr & MASKS[32*i +: 32]) == (BASES[32*i +: 32] & MASKS[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = SELW'(i);
      end
    end
    hit_mask = MASKS[32*hit_idx +: 32];
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sval_d  = sval_q;
    saddr_d = saddr_q;
    sdtw_d  = sdtw_q;
    srw_d   = srw_q;
    dtr_d   = dtr_q;
`ifdef MMIO_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid) begin
          if (hit) begin
            state_d = REQ;
            sel_d   = hit_idx;
            saddr_d = STRIP_BASE ? (addr & ~hit_mask) : addr;
            sdtw_d  = dtw;
            srw_d   = rw;
            for (int i = 0; i < int'(NCH); i++) begin
              sval_d[i] = (SELW'(i) == hit_idx);
            end
`ifdef MMIO_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            state_d = ERR;
            dtr_d   = ERR_DATA;
          end
        end
      end
      REQ: begin
        // Only the selected channel's srdy matters; a success on the same
        // edge the watchdog would expire takes priority over the timeout.
        if (srdy[sel_q]) begin
          state_d = RESP;
          sval_d  = '0;
          dtr_d   = srw_q ? 32'h0 : sdtr[32*sel_q +: 32];
        end
`ifdef MMIO_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ERR;
          sval_d  = '0;
          dtr_d   = ERR_DATA;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      sval_q  <= '0;
      saddr_q <= '0;
      sdtw_q  <= '0;
      srw_q   <= 1'b0;
      dtr_q   <= '0;
`ifdef MMIO_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sval_q  <= sval_d;
      saddr_q <= saddr_d;
      sdtw_q  <= sdtw_d;
      srw_q   <= srw_d;
      dtr_q   <= dtr_d;
`ifdef MMIO_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // ready/fault decode straight from the state register, so they fall
  // together with the state on an asynchronous reset.
  assign ready = (state_q == RESP) || (state_q == ERR);
  assign fault = (state_q == ERR);
  assign sval  = sval_q;
  assign saddr = saddr_q;
  assign sdtw  = sdtw_q;
  assign srw   = srw_q;
  assign dtr   = dtr_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_router.sv
// ============================================================================
// Module   : tb_mmio_router
// Purpose  : Directed self-checking bench for mmio_router with default
//            parameters (ch0 at 0x0xxx_xxxx, ch1 at 0x8xxx_xxxx).
//            Inputs change and outputs are sampled on the falling edge.
//            The timeout scenario is built only when MMIO_TIMEOUT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_router;

  logic        clk;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] dtw;
  logic [31:0] dtr;
  logic        rw;
  logic        fault;
  logic [1:0]  sval;
  logic [1:0]  srdy;
  logic [31:0] saddr;
  logic [31:0] sdtw;
  logic [63:0] sdtr;
  logic        srw;

  int compares;
  int mismatches;

  mmio_router dut (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .ready (ready),
    .addr  (addr),
    .dtw   (dtw),
    .dtr   (dtr),
    .rw    (rw),
    .fault (fault),
    .sval  (sval),
    .srdy  (srdy),
    .saddr (saddr),
    .sdtw  (sdtw),
    .sdtr  (sdtr),
    .srw   (srw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {ready, fault, sval, dtr} is the common observation vector below.

  task automatic test_reset();
    @(negedge clk);
    compares++;
    if ({ready, fault, sval, saddr, sdtw, srw, dtr} !== {1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      mismatches++;
      $display("FAIL reset_state: got rdy=%b flt=%b sval=%b saddr=%h sdtw=%h srw=%b dtr=%h, want all zero",
               ready, fault, sval, saddr, sdtw, srw, dtr);
    end
    reset = 1'b0;
    @(negedge clk);
    compares++;
    if ({ready, fault, sval} !== 4'b0000) begin
      mismatches++;
      $display("FAIL reset_release_idle: got rdy/flt/sval=%b, want 0000", {ready, fault, sval});
    end
  endtask

  task automatic test_read_ch0();
    valid = 1'b1; addr = 32'h0000_0010; rw = 1'b0; dtw = 32'h0;
    @(negedge clk);
    compares++;
    if ({sval, saddr, srw, ready} !== {2'b01, 32'h0000_0010, 1'b0, 1'b0}) begin
      mismatches++;
      $display("FAIL rd_ch0_req: got sval=%b saddr=%h srw=%b rdy=%b, want 01 00000010 0 0", sval, saddr, srw, ready);
    end
    @(negedge clk);
    compares++;
    if ({sval, ready} !== 3'b010) begin
      mismatches++;
      $display("FAIL rd_ch0_wait: got sval=%b rdy=%b, want 01 0", sval, ready);
    end
    srdy = 2'b01; sdtr[31:0] = 32'h1234_5678;
    @(negedge clk);
    srdy = 2'b00;
    compares++;
    if ({ready, fault, sval, dtr} !== {1'b1, 1'b0, 2'b00, 32'h1234_5678}) begin
      mismatches++;
      $display("FAIL rd_ch0_resp: got rdy=%b flt=%b sval=%b dtr=%h, want 1 0 00 12345678", ready, fault, sval, dtr);
    end
    valid = 1'b0;
    @(negedge clk);
    compares++;
    if ({ready, fault} !== 2'b00) begin
      mismatches++;
      $display("FAIL rd_ch0_single_pulse: got rdy=%b flt=%b, want 0 0", ready, fault);
    end
  endtask

  task automatic test_write_ch1();
    valid = 1'b1; addr = 32'h8000_0044; dtw = 32'hCAFE_F00D; rw = 1'b1;
    @(negedge clk);
    compares++;
    if ({sval, saddr, sdtw, srw, ready} !== {2'b10, 32'h0000_0044, 32'hCAFE_F00D, 1'b1, 1'b0}) begin
      mismatches++;
      $display("FAIL wr_ch1_req: got sval=%b saddr=%h sdtw=%h srw=%b rdy=%b, want 10 00000044 cafef00d 1 0",
               sval, saddr, sdtw, srw, ready);
    end
    srdy = 2'b10; sdtr[63:32] = 32'h5555_AAAA;
    @(negedge clk);
    srdy = 2'b00;
    compares++;
    if ({ready, fault, sval, dtr} !== {1'b1, 1'b0, 2'b00, 32'h0}) begin
      mismatches++;
      $display("FAIL wr_ch1_resp: got rdy=%b flt=%b sval=%b dtr=%h, want 1 0 00 00000000", ready, fault, sval, dtr);
    end
    valid = 1'b0; rw = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    valid = 1'b1; addr = 32'h4000_0000; rw = 1'b0;
    @(negedge clk);
    compares++;
    if ({ready, fault, sval, dtr} !== {1'b1, 1'b1, 2'b00, 32'hDEAD_BEEF}) begin
      mismatches++;
      $display("FAIL unmapped_err: got rdy=%b flt=%b sval=%b dtr=%h, want 1 1 00 deadbeef", ready, fault, sval, dtr);
    end
    valid = 1'b0;
    @(negedge clk);
    compares++;
    if ({ready, fault, sval} !== 4'b0000) begin
      mismatches++;
      $display("FAIL unmapped_after: got rdy/flt/sval=%b, want 0000", {ready, fault, sval});
    end
  endtask

  task automatic test_spurious_srdy();
    srdy = 2'b01; sdtr[31:0] = 32'hFFFF_0000;
    @(negedge clk);
    compares++;
    if ({ready, fault, sval} !== 4'b0000) begin
      mismatches++;
      $display("FAIL spur_idle: got rdy/flt/sval=%b, want 0000", {ready, fault, sval});
    end
    srdy = 2'b00;
    valid = 1'b1; addr = 32'h0000_0020; rw = 1'b0;
    @(negedge clk);
    srdy = 2'b10; sdtr[63:32] = 32'h1111_1111;
    @(negedge clk);
    compares++;
    if ({ready, sval} !== 3'b001) begin
      mismatches++;
      $display("FAIL spur_other_ch: got rdy=%b sval=%b, want 0 01", ready, sval);
    end
    srdy = 2'b01; sdtr[31:0] = 32'hA5A5_0F0F;
    @(negedge clk);
    srdy = 2'b00;
    compares++;
    if ({ready, fault, sval, dtr} !== {1'b1, 1'b0, 2'b00, 32'hA5A5_0F0F}) begin
      mismatches++;
      $display("FAIL spur_resp: got rdy=%b flt=%b sval=%b dtr=%h, want 1 0 00 a5a50f0f", ready, fault, sval, dtr);
    end
    valid = 1'b0;
    @(negedge clk);
    srdy = 2'b01;
    @(negedge clk);
    srdy = 2'b00;
    compares++;
    if ({ready, fault, sval} !== 4'b0000) begin
      mismatches++;
      $display("FAIL spur_idle_late: got rdy/flt/sval=%b, want 0000", {ready, fault, sval});
    end
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; addr = 32'h0000_0004; rw = 1'b0;
    @(negedge clk);
    srdy = 2'b01; sdtr[31:0] = 32'h0102_0304;
    @(negedge clk);
    srdy = 2'b00;
    compares++;
    if ({ready, dtr} !== {1'b1, 32'h0102_0304}) begin
      mismatches++;
      $display("FAIL b2b_first: got rdy=%b dtr=%h, want 1 01020304", ready, dtr);
    end
    addr = 32'h8000_0100; rw = 1'b1; dtw = 32'h0BAD_CAFE;
    @(negedge clk);
    compares++;
    if ({ready, sval} !== 3'b000) begin
      mismatches++;
      $display("FAIL b2b_idle_gap: got rdy=%b sval=%b, want 0 00", ready, sval);
    end
    @(negedge clk);
    compares++;
    if ({sval, saddr, sdtw, srw} !== {2'b10, 32'h0000_0100, 32'h0BAD_CAFE, 1'b1}) begin
      mismatches++;
      $display("FAIL b2b_second_req: got sval=%b saddr=%h sdtw=%h srw=%b, want 10 00000100 0badcafe 1",
               sval, saddr, sdtw, srw);
    end
    srdy = 2'b10;
    @(negedge clk);
    srdy = 2'b00;
    compares++;
    if ({ready, fault, dtr} !== {1'b1, 1'b0, 32'h0}) begin
      mismatches++;
      $display("FAIL b2b_second_resp: got rdy=%b flt=%b dtr=%h, want 1 0 00000000", ready, fault, dtr);
    end
    valid = 1'b0; rw = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    valid = 1'b1; addr = 32'h0000_0008; rw = 1'b0;
    @(negedge clk);
    compares++;
    if (sval !== 2'b01) begin
      mismatches++;
      $display("FAIL rst_mid_pre: got sval=%b, want 01", sval);
    end
    #1 reset = 1'b1;
    #1;
    compares++;
    if ({ready, fault, sval, dtr} !== {1'b0, 1'b0, 2'b00, 32'h0}) begin
      mismatches++;
      $display("FAIL rst_mid_async: got rdy=%b flt=%b sval=%b dtr=%h, want 0 0 00 00000000", ready, fault, sval, dtr);
    end
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b1; addr = 32'h8000_0008; rw = 1'b0;
    @(negedge clk);
    compares++;
    if ({sval, saddr, ready} !== {2'b10, 32'h0000_0008, 1'b0}) begin
      mismatches++;
      $display("FAIL rst_mid_new_req: got sval=%b saddr=%h rdy=%b, want 10 00000008 0", sval, saddr, ready);
    end
    srdy = 2'b10; sdtr[63:32] = 32'h600D_CAFE;
    @(negedge clk);
    srdy = 2'b00;
    compares++;
    if ({ready, fault, dtr} !== {1'b1, 1'b0, 32'h600D_CAFE}) begin
      mismatches++;
      $display("FAIL rst_mid_new_resp: got rdy=%b flt=%b dtr=%h, want 1 0 600dcafe", ready, fault, dtr);
    end
    valid = 1'b0;
    @(negedge clk);
  endtask

`ifdef MMIO_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    // Silent slave: sval must hold for 16 cycles, then an error completion.
    valid = 1'b1; addr = 32'h0000_0000; rw = 1'b0;
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if ({sval, ready} !== 3'b010) bad++;
    end
    compares++;
    if (bad != 0) begin
      mismatches++;
      $display("FAIL tmo_wait: %0d of 16 cycles lacked sval=01 rdy=0, want 0", bad);
    end
    @(negedge clk);
    compares++;
    if ({ready, fault, sval, dtr} !== {1'b1, 1'b1, 2'b00, 32'hDEAD_BEEF}) begin
      mismatches++;
      $display("FAIL tmo_err: got rdy=%b flt=%b sval=%b dtr=%h, want 1 1 00 deadbeef", ready, fault, sval, dtr);
    end
    valid = 1'b0;
    @(negedge clk);
    srdy = 2'b01; sdtr[31:0] = 32'h7777_7777;
    @(negedge clk);
    srdy = 2'b00;
    compares++;
    if ({ready, fault, sval} !== 4'b0000) begin
      mismatches++;
      $display("FAIL tmo_late_srdy: got rdy/flt/sval=%b, want 0000", {ready, fault, sval});
    end
    // srdy in the 16th sval cycle wins over the timeout.
    valid = 1'b1; addr = 32'h0000_0030; rw = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
    end
    srdy = 2'b01; sdtr[31:0] = 32'h1616_1616;
    @(negedge clk);
    srdy = 2'b00;
    compares++;
    if ({ready, fault, dtr} !== {1'b1, 1'b0, 32'h1616_1616}) begin
      mismatches++;
      $display("FAIL tmo_edge_success: got rdy=%b flt=%b dtr=%h, want 1 0 16161616", ready, fault, dtr);
    end
    valid = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    compares   = 0;
    mismatches = 0;
    reset = 1'b1;
    valid = 1'b0;
    addr  = 32'h0;
    dtw   = 32'h0;
    rw    = 1'b0;
    srdy  = 2'b00;
    sdtr  = 64'h0;
    test_reset();
    test_read_ch0();
    test_write_ch1();
    test_unmapped();
    test_spurious_srdy();
    test_back_to_back();
    test_reset_mid_req();
`ifdef MMIO_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule

`default_nettype wire
